// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared state, op and adder-control encodings for the divide sequencer
package riscv_div_pkg;
  typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX, S_DONE} state_e;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  typedef struct packed {logic en; logic op; logic funct7_5;} add_ctl_t;
  localparam add_ctl_t ADD_CTL  = '{en: 1'b1, op: 1'b0, funct7_5: 1'b0};
  localparam add_ctl_t SUB_CTL  = '{en: 1'b1, op: 1'b0, funct7_5: 1'b1};
  localparam add_ctl_t IDLE_CTL = '{en: 1'b0, op: 1'b0, funct7_5: 1'b0};
  function automatic logic is_signed(input logic [1:0] op);
    return op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic is_quot(input logic [1:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/div_sequencer.sv
// div_sequencer: restoring divider sequencing an external shared CLA add/sub unit.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from IDLE.
module div_sequencer
  import riscv_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_rs1,
  output logic [XLEN-1:0] add_rs2,
  output logic            add_en,
  output logic            add_op,
  output logic            add_funct7_5,
  input  logic [XLEN-1:0] add_result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  function automatic logic [XLEN-1:0] special_res(input logic q, input logic z, input logic [XLEN-1:0] a);
    return z ? (q ? '1 : a) : (q ? MIN : '0);
  endfunction
  state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [XLEN-1:0] s, sel;
  logic sa, sb, quot, forced, neg, ok, zero_in, ovf_in;
  add_ctl_t ctl;
  // the dividend register doubles as the quotient: bits shift in at the bottom
  assign s       = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
  assign quot    = is_quot(op_q);
  assign sa      = is_signed(op_q) & dvd_q[XLEN-1];
  assign sb      = is_signed(op_q) & dvs_q[XLEN-1];
  assign sel     = quot ? dvd_q : rem_q;
  assign forced  = ovf_q | (zero_q & quot);
  assign neg     = (quot ? q_neg_q : r_neg_q) & ~forced;
  assign ok      = rem_q[XLEN-1] | (s[XLEN-1] & ~dvs_q[XLEN-1]) | (~(s[XLEN-1] ^ dvs_q[XLEN-1]) & ~add_result[XLEN-1]);
  assign zero_in = Rs2 == '0;
  assign ovf_in  = is_signed(op) & (Rs1 == MIN) & (&Rs2);
  always_comb begin
    ctl = ((state_q == S_NEG_A) & sa) | ((state_q == S_NEG_B) & sb) | (state_q == S_ITER) | ((state_q == S_FIX) & neg) ? SUB_CTL : IDLE_CTL;
    add_rs1 = state_q == S_ITER ? s : '0;
    add_rs2 = ~ctl.en ? '0 : state_q == S_NEG_A ? dvd_q : state_q == S_FIX ? sel : dvs_q;
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d = op;
        dvd_d = Rs1;
        dvs_d = Rs2;
        rem_d = '0;
        cnt_d = '0;
        q_neg_d = 1'b0;
        r_neg_d = 1'b0;
        zero_d = zero_in;
        ovf_d = ovf_in;
`ifdef DIV_EARLY_OUT_EN
        state_d = zero_in | ovf_in ? S_DONE : S_NEG_A;
        result_d = zero_in | ovf_in ? special_res(is_quot(op), zero_in, Rs1) : result_q;
`else
        state_d = S_NEG_A;
`endif
      end
      S_NEG_A: begin
        dvd_d = sa ? add_result : dvd_q;
        r_neg_d = sa;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        dvs_d = sb ? add_result : dvs_q;
        q_neg_d = r_neg_q ^ sb;
        cnt_d = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = ok ? add_result : s;
        dvd_d = {dvd_q[XLEN-2:0], ok};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? S_FIX : S_ITER;
      end
      S_FIX: begin
        result_d = forced ? special_res(quot, zero_q, '0) : neg ? add_result : sel;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      result_q <= result_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign result = result_q;
  assign {add_en, add_op, add_funct7_5} = ctl;
endmodule
